// File: rtl/alu_seq_if.sv
// alu_seq_if: command, response and external-ALU signals of alu_seq.
// The slave modport is the sequencer side; the master modport is its environment.
interface alu_seq_if #(parameter int WIDTH = 8);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [1:0]       cmd_rd;
    logic [1:0]       cmd_ra;
    logic [1:0]       cmd_rb;
    logic             cmd_imm_en;
    logic [WIDTH-1:0] cmd_imm;
    logic [WIDTH-1:0] alu_bus_a;
    logic [WIDTH-1:0] alu_bus_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             alu_negative;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_negative;
    logic             rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
        input  alu_out, alu_zero, alu_negative, rsp_ready,
        output cmd_ready, alu_bus_a, alu_bus_b, alu_sel,
        output rsp_valid, rsp_data, rsp_zero, rsp_negative, rsp_err
    );
    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
        output alu_out, alu_zero, alu_negative, rsp_ready,
        input  cmd_ready, alu_bus_a, alu_bus_b, alu_sel,
        input  rsp_valid, rsp_data, rsp_zero, rsp_negative, rsp_err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: IDLE/EXEC/RESP sequencer feeding an external ALU from a 4-entry register file.
// Define ALU_SEQ_DIVZERO_ERR_EN to trap div/mod by zero (rsp_err, write suppressed).
module alu_seq #(parameter int WIDTH = 8) (
    input  logic       clk,
    input  logic       rstn,
    alu_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rf_q [4];
    logic [WIDTH-1:0] a_q, b_q, data_q;
    logic [2:0]       sel_q;
    logic [1:0]       rd_q;
    logic             zero_q, neg_q, err_q, divz;

`ifdef ALU_SEQ_DIVZERO_ERR_EN
    assign divz = (sel_q == 3'd3 || sel_q == 3'd4) && b_q == '0;
`else
    assign divz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rf_q    <= '{default: '0};
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.cmd_valid) begin
                a_q   <= rf_q[bus.cmd_ra];
                b_q   <= bus.cmd_imm_en ? bus.cmd_imm : rf_q[bus.cmd_rb];
                sel_q <= bus.cmd_op;
                rd_q  <= bus.cmd_rd;
                err_q <= 1'b0;
            end
            if (state_q == EXEC) begin
                data_q <= divz ? '0 : bus.alu_out;
                zero_q <= bus.alu_zero;
                neg_q  <= bus.alu_negative;
                err_q  <= divz;
                if (!divz) rf_q[rd_q] <= bus.alu_out;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.cmd_valid ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready    = state_q == IDLE;
        bus.rsp_valid    = state_q == RESP;
        bus.alu_bus_a    = a_q;
        bus.alu_bus_b    = b_q;
        bus.alu_sel      = sel_q;
        bus.rsp_data     = data_q;
        bus.rsp_zero     = zero_q;
        bus.rsp_negative = neg_q;
        bus.rsp_err      = err_q;
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a behavioural external ALU.
// Build with ALU_SEQ_DIVZERO_ERR_EN defined to check the divide-by-zero trap variant.
module tb_alu_seq;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         z, n, e;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] rf_m [4];
    exp_t sb [$];

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    function automatic logic [W-1:0] alu_fn(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        int sa, sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return W'(sa * sbv);
            3'd3:    return sbv == 0 ? '0 : W'(sa / sbv);
            3'd4:    return sbv == 0 ? '0 : W'(sa % sbv);
            default: return a;
        endcase
    endfunction

    assign bus.alu_out      = alu_fn(bus.alu_sel, bus.alu_bus_a, bus.alu_bus_b);
    assign bus.alu_zero     = bus.alu_out == '0;
    assign bus.alu_negative = bus.alu_out[W-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                          input logic [1:0] rb, input logic ie, input logic [W-1:0] imm, input int hold);
        logic [W-1:0] a, b, r;
        logic dz;
        exp_t e;
        int n;
        a  = rf_m[ra];
        b  = ie ? imm : rf_m[rb];
        r  = alu_fn(op, a, b);
        dz = (op == 3'd3 || op == 3'd4) && b == '0;
        e.z = r == '0;
        e.n = r[W-1];
`ifdef ALU_SEQ_DIVZERO_ERR_EN
        e.e = dz;
        e.d = dz ? '0 : r;
        if (!dz) rf_m[rd] = r;
`else
        e.e = 1'b0;
        e.d = r;
        rf_m[rd] = r;
`endif
        sb.push_back(e);
        chk("cmd_ready", bus.cmd_ready, 1);
        bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_ra = ra; bus.cmd_rb = rb;
        bus.cmd_imm_en = ie; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("exec_valid", bus.rsp_valid, 0);
        chk("exec_ready", bus.cmd_ready, 0);
        chk("bus_a", bus.alu_bus_a, a);
        chk("bus_b", bus.alu_bus_b, b);
        chk("alu_sel", bus.alu_sel, op);
        n = 0;
        while (!bus.rsp_valid && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_data", bus.rsp_data, sb[0].d);
            chk("hold_ready", bus.cmd_ready, 0);
            chk("hold_bus_b", bus.alu_bus_b, b);
            bus.cmd_valid = (i == 1);
            bus.cmd_op = 3'd0; bus.cmd_rd = 2'd0; bus.cmd_imm_en = 1'b1; bus.cmd_imm = 8'h77;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        e = sb.pop_front();
        chk("rsp_data", bus.rsp_data, e.d);
        chk("rsp_zero", bus.rsp_zero, e.z);
        chk("rsp_neg", bus.rsp_negative, e.n);
        chk("rsp_err", bus.rsp_err, e.e);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("idle_ready", bus.cmd_ready, 1);
        chk("idle_valid", bus.rsp_valid, 0);
    endtask

    task automatic read_reg(input logic [1:0] r);
        do_cmd(3'd5, r, r, 2'd0, 1'b1, '0, 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_ra = '0;
        bus.cmd_rb = '0; bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0; bus.rsp_ready = 1'b0;
        rf_m = '{default: '0};
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_data", bus.rsp_data, 0);
        chk("rst_err", bus.rsp_err, 0);
        chk("rst_bus_a", bus.alu_bus_a, 0);
        chk("rst_sel", bus.alu_sel, 0);
        rstn = 1'b1;
        @(negedge clk);
        do_cmd(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'd5, 0);
        read_reg(2'd1);
        do_cmd(3'd1, 2'd2, 2'd1, 2'd0, 1'b1, 8'd7, 0);
        read_reg(2'd2);
        do_cmd(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'd16, 0);
        do_cmd(3'd2, 2'd3, 2'd1, 2'd0, 1'b1, 8'd16, 0);
        read_reg(2'd3);
        do_cmd(3'd0, 2'd3, 2'd0, 2'd0, 1'b1, 8'h33, 0);
        do_cmd(3'd3, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 0);
        read_reg(2'd3);
        do_cmd(3'd4, 2'd1, 2'd2, 2'd0, 1'b1, 8'h00, 0);
        do_cmd(3'd3, 2'd2, 2'd2, 2'd0, 1'b1, 8'd2, 5);
        do_cmd(3'd4, 2'd1, 2'd2, 2'd0, 1'b1, 8'd3, 0);
        read_reg(2'd1);
        for (int k = 0; k < 24; k++)
            do_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), k % 4);
        // abort a write to r2 while it is in EXEC
        bus.cmd_op = 3'd0; bus.cmd_rd = 2'd2; bus.cmd_ra = 2'd1; bus.cmd_imm_en = 1'b1;
        bus.cmd_imm = 8'd9; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("abort_valid", bus.rsp_valid, 0);
        #2;
        rstn = 1'b1;
        rf_m = '{default: '0};
        @(negedge clk);
        chk("abort_ready", bus.cmd_ready, 1);
        chk("abort_valid2", bus.rsp_valid, 0);
        chk("abort_data", bus.rsp_data, 0);
        chk("abort_bus_a", bus.alu_bus_a, 0);
        read_reg(2'd2);
        read_reg(2'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
